link_order_arb: RTL
===================

LINK_ORDER_ARB -- requirements
Module: link_order_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, node address width.
REQ-002 Parameter DATA_WIDTH, default 16, node data width.
REQ-003 Parameter TABLE_WIDTH, default 8, table index width.
REQ-004 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-005 Port clk  in  1  single clock; all logic on its rising edge.
REQ-006 Port rst  in  1  reset; synchronous, active-high.
REQ-007 Port req_valid  in  NUM_REQ  per-requester order valid.
REQ-008 Port req_busy  out  NUM_REQ  per-requester stall; transfer when valid=1 and busy=0 at a rising edge.
REQ-009 Port req_type  in  2*NUM_REQ  per-requester order type, packed, requester i at [2i+1:2i].
REQ-010 Port req_table / req_node / req_data  in  NUM_REQ*TABLE_WIDTH / NUM_REQ*ADDR_WIDTH / NUM_REQ*DATA_WIDTH  packed per requester, same packing as req_type.
REQ-011 Port order_valid  out  1; order_busy  in  1; order_type  out  2; order_table  out  TABLE_WIDTH; order_node  out  ADDR_WIDTH; order_data  out  DATA_WIDTH  shared order port to the link-table controller.
REQ-012 Port dout_valid  in  1; dout_busy  out  1; dout_data  in  DATA_WIDTH  read-response port from the controller.
REQ-013 Port rsp_valid  out  NUM_REQ; rsp_busy  in  NUM_REQ; rsp_data  out  DATA_WIDTH  read response routed to the owning requester.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_RSP.
REQ-015 IDLE: among asserted req_valid, grant the first index at or after rr_ptr (wrapping modulo NUM_REQ); req_busy[grant]=0 combinationally, all other req_busy=1.
REQ-016 IDLE with no req_valid: all req_busy=1, stay IDLE, rr_ptr unchanged.
REQ-017 On grant: capture type/table/node/data and owner index into registers, set rr_ptr=(grant+1) mod NUM_REQ, go to ISSUE.
REQ-018 ISSUE: order_valid=1 with the captured fields held stable; all req_busy=1.
REQ-019 ISSUE exit on order_valid=1 and order_busy=0 at an edge: type READ (2'b11) -> WAIT_RSP, else -> IDLE.
REQ-020 Latency: a request accepted at edge t SHALL present order_valid=1 from t+1; with order_busy=0, the next grant may occur at edge t+2.
REQ-021 WAIT_RSP: rsp_valid[owner]=dout_valid, other rsp_valid=0, rsp_data=dout_data, dout_busy=rsp_busy[owner] (combinational pass-through).
REQ-022 WAIT_RSP exit on dout_valid=1 and dout_busy=0 -> IDLE; no new order issued while a read is outstanding.
REQ-023 Outside WAIT_RSP: dout_busy=1, all rsp_valid=0; unsolicited dout_valid stalls and is never forwarded.
REQ-024 Order type values: APPE 2'b00, DELE 2'b01, CHAG 2'b10, READ 2'b11; widths pass through unchanged, no arithmetic on fields.
REQ-025 A requester dropping req_valid before grant SHALL lose no state; no grant is issued to a deasserted requester.

Reset
REQ-026 rst=1 at an edge: state IDLE, rr_ptr=0, order_valid=0, captured fields and owner cleared to 0.
REQ-027 During/after reset: req_busy all 1 while rst=1, dout_busy=1, rsp_valid all 0.
REQ-028 Reset mid-ISSUE or mid-WAIT_RSP SHALL abandon the order/read without forwarding; order_valid=0 from the reset edge onward.

Structure
REQ-029 Shared package link_pkg SHALL hold the order-type encoding constants and default widths used by link_order_arb and the link-table controller.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector and rr_ptr, outputs one-hot grant and index).

Verification
REQ-031 Single requester 2 APPE (table 3, node 1, data 111), order_busy=0 -> req_busy[2]=0 one cycle, order_valid=1 next cycle with identical fields, back to IDLE.
REQ-032 All 4 req_valid held, 8 orders -> grant order 0,1,2,3,0,1,2,3; no requester granted twice while another waits.
REQ-033 order_busy held 1 for 5 cycles in ISSUE -> order_valid and fields stable all 5 cycles, all req_busy=1; accepted on first order_busy=0 edge.
REQ-034 Requester 1 READ (table 3, node 2); controller returns dout_data=112 with rsp_busy[1]=1 for 3 cycles -> dout_busy=1 for 3 cycles, then rsp_valid[1]=1, rsp_data=112, other rsp_valid=0; requester 0 pending not granted until completion.
REQ-035 rst=1 pulse while in WAIT_RSP -> IDLE, rr_ptr=0, dout_busy=1; later dout_valid not forwarded to any rsp_valid.
REQ-036 dout_valid=1 while IDLE -> dout_busy=1, rsp_valid all 0, state stays IDLE.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the link-table order path: order-type encoding,
// default field widths and the arbiter state type.
package link_pkg;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int DATA_WIDTH_DEF  = 16;
  localparam int TABLE_WIDTH_DEF = 8;
  localparam int NUM_REQ_DEF     = 4;

  localparam logic [1:0] ORD_APPE = 2'b00;
  localparam logic [1:0] ORD_DELE = 2'b01;
  localparam logic [1:0] ORD_CHAG = 2'b10;
  localparam logic [1:0] ORD_READ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// ptr is assumed to be below NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/link_order_arb.sv
// Arbitrates per-requester link-table orders onto one order port and routes
// the read response back to the requester that issued the read.
//
// state       | meaning
// ST_IDLE     | waiting for a request; grant is combinational
// ST_ISSUE    | captured order presented on the order port
// ST_WAIT_RSP | read outstanding; response passes through to the owner
module link_order_arb
  import link_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int TABLE_WIDTH = TABLE_WIDTH_DEF,
  parameter int NUM_REQ     = NUM_REQ_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_busy,
  input  logic [2*NUM_REQ-1:0]           req_type,
  input  logic [NUM_REQ*TABLE_WIDTH-1:0] req_table,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_node,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic                           order_valid,
  input  logic                           order_busy,
  output logic [1:0]                     order_type,
  output logic [TABLE_WIDTH-1:0]         order_table,
  output logic [ADDR_WIDTH-1:0]          order_node,
  output logic [DATA_WIDTH-1:0]          order_data,
  input  logic                           dout_valid,
  output logic                           dout_busy,
  input  logic [DATA_WIDTH-1:0]          dout_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_busy,
  output logic [DATA_WIDTH-1:0]          rsp_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              in_idle;
  logic              in_wait;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Reset gates every handshake output so nothing transfers during reset.
  assign in_idle  = (state == ST_IDLE) && !rst;
  assign in_wait  = (state == ST_WAIT_RSP) && !rst;
  assign req_busy = in_idle ? ~gnt_onehot : '1;
  assign dout_busy = in_wait ? rsp_busy[owner] : 1'b1;
  assign rsp_data = dout_data;

  always_comb begin
    rsp_valid = '0;
    if (in_wait) rsp_valid[owner] = dout_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      order_valid <= 1'b0;
      order_type  <= '0;
      order_table <= '0;
      order_node  <= '0;
      order_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            owner       <= gnt_idx;
            order_type  <= req_type[2*gnt_idx +: 2];
            order_table <= req_table[gnt_idx*TABLE_WIDTH +: TABLE_WIDTH];
            order_node  <= req_node[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            order_data  <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr      <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            order_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!order_busy) begin
            order_valid <= 1'b0;
            state       <= (order_type == ORD_READ) ? ST_WAIT_RSP : ST_IDLE;
          end
        end
        ST_WAIT_RSP: begin
          if (dout_valid && !dout_busy) state <= ST_IDLE;
        end
        default: begin
          order_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
